// File: rtl/sipo_frame_rx.sv
// Serial-in, parallel-out frame receiver for an LSB-first stream.
// Each completed WIDTH-bit word goes into a single-entry valid/ready buffer, with sticky overrun and restart flags.
module sipo_frame_rx #(
  parameter int WIDTH = 4,
  parameter int CW    = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             si_i,
  input  logic             si_en_i,
  input  logic             start_i,
  input  logic             clr_err_i,
  input  logic             pready_i,
  output logic [WIDTH-1:0] pdata_o,
  output logic             pvalid_o,
  output logic             busy_o,
  output logic             overrun_o,
  output logic             frame_err_o
);

  // state | meaning
  // IDLE  | waiting for a qualified start bit
  // SHIFT | frame in progress, bit counter holds the index of the next bit
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] pdata_q, pdata_d;
  logic             pvalid_q, pvalid_d;
  logic             overrun_q, overrun_d;
  logic             frame_err_q, frame_err_d;

  logic             in_frame;
  logic             sample;
  logic             resync;
  logic             frame_restart;
  logic             last_bit;
  logic             drop_word;
  logic [CW-1:0]    bit_idx;
  logic [WIDTH-1:0] sr_shift;

  // The oldest bit falls out of the shift on the completing edge and is never read.
  logic             unused_sr_lsb;
  assign unused_sr_lsb = sr_q[0];

  assign in_frame = (state_q == ST_SHIFT);

  always_comb begin
    resync        = si_en_i & start_i;
    sample        = si_en_i & (start_i | in_frame);
    frame_restart = resync & in_frame;
    bit_idx       = resync ? '0 : cnt_q;
    last_bit      = sample & (bit_idx == LAST_IDX);
    sr_shift      = {si_i, (resync ? {(WIDTH-1){1'b0}} : sr_q[WIDTH-1:1])};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    if (sample) begin
      sr_d = sr_shift;
      if (last_bit) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        state_d = ST_SHIFT;
        cnt_d   = bit_idx + CW'(1);
      end
    end
  end

  // A completed word is loaded only if the buffer is empty or draining this edge.
  always_comb begin
    pdata_d   = pdata_q;
    pvalid_d  = pvalid_q;
    drop_word = 1'b0;
    if (last_bit) begin
      if (!pvalid_q || pready_i) begin
        pdata_d  = sr_shift;
        pvalid_d = 1'b1;
      end else begin
        drop_word = 1'b1;
      end
    end else if (pvalid_q && pready_i) begin
      pvalid_d = 1'b0;
    end
  end

  always_comb begin
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    if (clr_err_i) begin
      overrun_d   = 1'b0;
      frame_err_d = 1'b0;
    end
    if (drop_word) begin
      overrun_d = 1'b1;
    end
    if (frame_restart) begin
      frame_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      pdata_q     <= '0;
      pvalid_q    <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      pdata_q     <= pdata_d;
      pvalid_q    <= pvalid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign pdata_o     = pdata_q;
  assign pvalid_o    = pvalid_q;
  assign busy_o      = in_frame;
  assign overrun_o   = overrun_q;
  assign frame_err_o = frame_err_q;

endmodule
